conv_mac_ctrl: RTL and testbench

CONV_MAC_CTRL -- requirements
Module: conv_mac_ctrl

---
 rtl/conv_mac_ctrl.sv | 144 ++++++++++++++
 tb/tb_conv_mac_ctrl.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/conv_mac_ctrl.sv
// Dot-product sequencer for an external pipelined mult_add unit.
// Issues operand groups, tracks them through the multiplier latency and accumulates the products.
module conv_mac_ctrl #(
  parameter int DW     = 16,
  parameter int LEN_W  = 8,
  parameter int ACC_W  = 32,
  parameter int MA_LAT = 2
) (
  input  logic             sys_clk_i,
  input  logic             sys_rst_i,
  input  logic             cfg_start_i,
  input  logic [LEN_W-1:0] cfg_len_i,
  input  logic             cfg_is_add_i,
  output logic             busy_o,
  input  logic             op_valid_i,
  output logic             op_ready_o,
  input  logic [DW-1:0]    op_a0_i,
  input  logic [DW-1:0]    op_a1_i,
  input  logic [DW-1:0]    op_b0_i,
  input  logic [DW-1:0]    op_b1_i,
  output logic [DW-1:0]    ma_a0_o,
  output logic [DW-1:0]    ma_a1_o,
  output logic [DW-1:0]    ma_b0_o,
  output logic [DW-1:0]    ma_b1_o,
  output logic             ma_addsub_o,
  input  logic [DW-1:0]    ma_p_i,
  output logic             res_valid_o,
  input  logic             res_ready_i,
  output logic [ACC_W-1:0] res_data_o
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FEED  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] iss_q, iss_d;
  logic [LEN_W-1:0] ret_q, ret_d;
  logic             mode_q, mode_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [MA_LAT-1:0] tag_q, tag_d;
  logic [DW-1:0]    a0_q, a0_d, a1_q, a1_d, b0_q, b0_d, b1_q, b1_d;

  logic             op_hs;
  logic             retire;
  logic [ACC_W-1:0] p_ext;

  assign op_hs  = (state_q == S_FEED) && op_valid_i;
  // Oldest tag bit marks the edge where the product for that group is on ma_p_i.
  assign retire = tag_q[MA_LAT-1];
  assign p_ext  = {{(ACC_W-DW){ma_p_i[DW-1]}}, ma_p_i};

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    iss_d   = iss_q;
    ret_d   = ret_q;
    mode_d  = mode_q;
    acc_d   = acc_q;
    a0_d    = a0_q;
    a1_d    = a1_q;
    b0_d    = b0_q;
    b1_d    = b1_q;
    tag_d   = tag_q;

    tag_d[0] = op_hs;
    for (int i = 1; i < MA_LAT; i++) tag_d[i] = tag_q[i-1];

    if (retire) begin
      acc_d = acc_q + p_ext;
      ret_d = ret_q + LEN_W'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (cfg_start_i) begin
          len_d   = cfg_len_i;
          mode_d  = cfg_is_add_i;
          acc_d   = '0;
          iss_d   = '0;
          ret_d   = '0;
          state_d = (cfg_len_i == '0) ? S_DONE : S_FEED;
        end
      end
      S_FEED: begin
        if (op_hs) begin
          a0_d  = op_a0_i;
          a1_d  = op_a1_i;
          b0_d  = op_b0_i;
          b1_d  = op_b1_i;
          iss_d = iss_q + LEN_W'(1);
          if ((iss_q + LEN_W'(1)) == len_q) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (retire && ((ret_q + LEN_W'(1)) == len_q)) state_d = S_DONE;
      end
      default: begin
        if (res_ready_i) state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
    if (sys_rst_i) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      iss_q   <= '0;
      ret_q   <= '0;
      mode_q  <= 1'b0;
      acc_q   <= '0;
      tag_q   <= '0;
      a0_q    <= '0;
      a1_q    <= '0;
      b0_q    <= '0;
      b1_q    <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      iss_q   <= iss_d;
      ret_q   <= ret_d;
      mode_q  <= mode_d;
      acc_q   <= acc_d;
      tag_q   <= tag_d;
      a0_q    <= a0_d;
      a1_q    <= a1_d;
      b0_q    <= b0_d;
      b1_q    <= b1_d;
    end
  end

  assign busy_o      = (state_q != S_IDLE);
  assign op_ready_o  = (state_q == S_FEED);
  assign res_valid_o = (state_q == S_DONE);
  assign res_data_o  = acc_q;
  assign ma_addsub_o = mode_q;
  assign ma_a0_o     = a0_q;
  assign ma_a1_o     = a1_q;
  assign ma_b0_o     = b0_q;
  assign ma_b1_o     = b1_q;

endmodule

// File: tb/tb_conv_mac_ctrl.sv
// Directed bench for conv_mac_ctrl with a two-cycle mult_add model.
// Expected results are queued at job start and consumed by an independent result monitor.
module tb_conv_mac_ctrl;
  localparam int DW     = 16;
  localparam int LEN_W  = 8;
  localparam int ACC_W  = 32;
  localparam int MA_LAT = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             cfg_start_i = 1'b0;
  logic [LEN_W-1:0] cfg_len_i = '0;
  logic             cfg_is_add_i = 1'b0;
  logic             busy_o;
  logic             op_valid_i = 1'b0;
  logic             op_ready_o;
  logic [DW-1:0]    op_a0_i = '0, op_a1_i = '0, op_b0_i = '0, op_b1_i = '0;
  logic [DW-1:0]    ma_a0_o, ma_a1_o, ma_b0_o, ma_b1_o;
  logic             ma_addsub_o;
  logic [DW-1:0]    ma_p_i = '0;
  logic             res_valid_o;
  logic             res_ready_i = 1'b1;
  logic [ACC_W-1:0] res_data_o;

  always #5 clk = ~clk;

  conv_mac_ctrl #(.DW(DW), .LEN_W(LEN_W), .ACC_W(ACC_W), .MA_LAT(MA_LAT)) dut (
    .sys_clk_i(clk), .sys_rst_i(rst),
    .cfg_start_i(cfg_start_i), .cfg_len_i(cfg_len_i), .cfg_is_add_i(cfg_is_add_i),
    .busy_o(busy_o),
    .op_valid_i(op_valid_i), .op_ready_o(op_ready_o),
    .op_a0_i(op_a0_i), .op_a1_i(op_a1_i), .op_b0_i(op_b0_i), .op_b1_i(op_b1_i),
    .ma_a0_o(ma_a0_o), .ma_a1_o(ma_a1_o), .ma_b0_o(ma_b0_o), .ma_b1_o(ma_b1_o),
    .ma_addsub_o(ma_addsub_o), .ma_p_i(ma_p_i),
    .res_valid_o(res_valid_o), .res_ready_i(res_ready_i), .res_data_o(res_data_o)
  );

  // mult_add model: one register stage after the DUT's operand registers gives MA_LAT=2.
  logic signed [DW-1:0] sa0, sa1, sb0, sb1;
  assign sa0 = $signed(ma_a0_o);
  assign sa1 = $signed(ma_a1_o);
  assign sb0 = $signed(ma_b0_o);
  assign sb1 = $signed(ma_b1_o);
  always @(posedge clk) begin
    if (ma_addsub_o) ma_p_i <= DW'(sa0 * sb0 + sa1 * sb1);
    else             ma_p_i <= DW'(sa0 * sb0 - sa1 * sb1);
  end

  int n_checks = 0;
  int n_pass   = 0;
  logic [ACC_W-1:0] exp_q[$];
  logic [ACC_W-1:0] cur_exp = '0;
  logic             prev_valid = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Result monitor: pops on each new result, then checks the value every cycle it is held.
  always @(negedge clk) begin
    if (rst) begin
      prev_valid = 1'b0;
    end else begin
      if (res_valid_o && !prev_valid) begin
        if (exp_q.size() == 0) chk("res_unexpected", 64'(res_valid_o), 64'd0);
        else cur_exp = exp_q.pop_front();
      end
      if (res_valid_o) chk("res_data", 64'(res_data_o), 64'(cur_exp));
      prev_valid = res_valid_o;
    end
  end

  task automatic start_job(input int len, input bit add, input logic [ACC_W-1:0] exp);
    exp_q.push_back(exp);
    cfg_len_i    = LEN_W'(len);
    cfg_is_add_i = add;
    cfg_start_i  = 1'b1;
    @(negedge clk);
    cfg_start_i  = 1'b0;
  endtask

  task automatic send(input int gap, input int a0, input int a1, input int b0, input int b1);
    int k;
    op_valid_i = 1'b0;
    repeat (gap) @(negedge clk);
    op_a0_i = DW'(a0);
    op_a1_i = DW'(a1);
    op_b0_i = DW'(b0);
    op_b1_i = DW'(b1);
    op_valid_i = 1'b1;
    k = 0;
    while (!op_ready_o && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (!op_ready_o) chk("op_ready_timeout", 64'(op_ready_o), 64'd1);
    @(negedge clk);
  endtask

  task automatic wait_valid(input string name);
    int k;
    k = 0;
    while (!res_valid_o && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk(name, 64'(res_valid_o), 64'd1);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"},   64'(busy_o),      64'd0);
    chk({tag, "_ready"},  64'(op_ready_o),  64'd0);
    chk({tag, "_valid"},  64'(res_valid_o), 64'd0);
    chk({tag, "_addsub"}, 64'(ma_addsub_o), 64'd0);
    chk({tag, "_ma"},     64'({ma_a0_o, ma_a1_o, ma_b0_o, ma_b1_o}), 64'd0);
    chk({tag, "_data"},   64'(res_data_o),  64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    // add mode, three back-to-back groups of p=23
    start_job(3, 1'b1, 32'd69);
    send(0, 2, 3, 4, 5);
    send(0, 2, 3, 4, 5);
    send(0, 2, 3, 4, 5);
    op_valid_i = 1'b0;
    chk("j1_ma_a1", 64'(ma_a1_o), 64'd3);
    chk("j1_ma_b1", 64'(ma_b1_o), 64'd5);
    chk("j1_addsub", 64'(ma_addsub_o), 64'd1);
    chk("j1_drain_ready", 64'(op_ready_o), 64'd0);
    chk("j1_lat0", 64'(res_valid_o), 64'd0);
    @(negedge clk);
    chk("j1_lat1", 64'(res_valid_o), 64'd0);
    @(negedge clk);
    chk("j1_lat2", 64'(res_valid_o), 64'd1);
    @(negedge clk);
    chk("j1_idle", 64'(busy_o), 64'd0);

    // sub mode, p=-10 twice
    start_job(2, 1'b0, 32'hFFFF_FFEC);
    chk("j2_addsub_a", 64'(ma_addsub_o), 64'd0);
    send(0, 1, 3, 2, 4);
    chk("j2_addsub_b", 64'(ma_addsub_o), 64'd0);
    send(0, 1, 3, 2, 4);
    op_valid_i = 1'b0;
    wait_valid("j2_done");
    chk("j2_addsub_c", 64'(ma_addsub_o), 64'd0);
    @(negedge clk);
    chk("j2_idle", 64'(busy_o), 64'd0);

    // zero-length job
    start_job(0, 1'b1, 32'd0);
    chk("j3_done_next", 64'(res_valid_o), 64'd1);
    chk("j3_ready_a", 64'(op_ready_o), 64'd0);
    @(negedge clk);
    chk("j3_ready_b", 64'(op_ready_o), 64'd0);
    chk("j3_idle", 64'(busy_o), 64'd0);

    // gaps in operand stream, result stalled, stray start during DONE
    res_ready_i = 1'b0;
    start_job(4, 1'b1, 32'd896);
    send(0, 1, 2, 3, 4);
    send(1, 5, -1, 2, 3);
    send(2, -4, 6, 7, 1);
    send(3, 100, 0, 9, -5);
    op_valid_i = 1'b0;
    wait_valid("j4_done");
    cfg_len_i   = 8'd5;
    cfg_start_i = 1'b1;
    @(negedge clk);
    cfg_start_i = 1'b0;
    chk("j4_start_ignored", 64'(res_valid_o), 64'd1);
    chk("j4_ready_low", 64'(op_ready_o), 64'd0);
    repeat (4) @(negedge clk);
    chk("j4_still_waiting", 64'(res_valid_o), 64'd1);
    res_ready_i = 1'b1;
    @(negedge clk);
    chk("j4_valid_drop", 64'(res_valid_o), 64'd0);
    chk("j4_idle", 64'(busy_o), 64'd0);
    chk("j4_hold", 64'(res_data_o), 64'd896);

    // reset mid-job after one of four groups
    start_job(4, 1'b1, 32'd0);
    send(0, 2, 3, 4, 5);
    op_valid_i = 1'b0;
    repeat (2) @(negedge clk);
    chk("j5_pre_reset", 64'(res_data_o), 64'd23);
    rst = 1'b1;
    exp_q.delete();
    #1;
    chk_all_zero("midrst");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("j5_no_stale", 64'(res_data_o), 64'd0);
    start_job(1, 1'b1, 32'd7);
    send(0, 7, 0, 1, 0);
    op_valid_i = 1'b0;
    wait_valid("j5_done");
    @(negedge clk);
    chk("j5_idle", 64'(busy_o), 64'd0);
    chk("j5_hold", 64'(res_data_o), 64'd7);

    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
